// File: rtl/sqrt_unit_arbiter_pkg.sv
// sqrt_unit_arbiter_pkg: shared widths, defaults and FSM state type for the sqrt arbiter
package sqrt_unit_arbiter_pkg;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int SIG_W = 1 + LAMP_FLOAT_F_DW;
  localparam int RES_W = 2 * SIG_W;
  localparam int SQRT_ARB_TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} sqrt_arb_state_t;
endpackage

// File: rtl/sqrt_unit_arbiter_if.sv
// sqrt_unit_arbiter_if: requester and datapath signals between the arbiter and its neighbours
interface sqrt_unit_arbiter_if #(parameter int NUM_REQ = 4);
  import sqrt_unit_arbiter_pkg::*;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*SIG_W-1:0] req_sig_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       rsp_valid_o;
  logic [RES_W-1:0]         rsp_res_o;
  logic                     rsp_err_o;
  logic                     sqrt_do_o;
  logic [SIG_W-1:0]         sqrt_s_o;
  logic                     sqrt_valid_i;
  logic [RES_W-1:0]         sqrt_res_i;
  modport slave (
    input  req_valid_i, req_sig_i, sqrt_valid_i, sqrt_res_i,
    output req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_s_o
  );
  modport master (
    output req_valid_i, req_sig_i, sqrt_valid_i, sqrt_res_i,
    input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_s_o
  );
endinterface

// File: rtl/sqrt_unit_arbiter_rr_pick.sv
// rr_priority_pick: first set request at or above ptr, wrapping around
module rr_priority_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_onehot,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);
  logic [IW-1:0] w_idx;
  // scan from the farthest offset down so the nearest request to ptr wins
  always_comb begin
    o_gnt_idx = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_gnt_idx = w_idx;
        o_any = 1'b1;
      end
    end
    o_gnt_onehot = o_any ? N'(1) << o_gnt_idx : '0;
  end
endmodule

// File: rtl/sqrt_unit_arbiter.sv
// sqrt_unit_arbiter: round-robin sharing of one sqrt datapath with a watchdog on each launch
module sqrt_unit_arbiter
  import sqrt_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = SQRT_ARB_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  sqrt_unit_arbiter_if.slave     arb,
  output logic                   busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC);
  sqrt_arb_state_t    r_state, w_next;
  logic [IW-1:0]      r_gnt, r_ptr, w_idx;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_any, w_expire;
  logic [SIG_W-1:0]   r_sig;
  logic [RES_W-1:0]   r_res;
  logic               r_err;
  logic [WW-1:0]      r_wd;

  assign w_expire = r_wd == WW'(TIMEOUT_CYC - 1);

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .i_req       (arb.req_valid_i),
    .i_ptr       (r_ptr),
    .o_gnt_onehot(w_onehot),
    .o_gnt_idx   (w_idx),
    .o_any       (w_any)
  );

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= ARB_IDLE;
    else r_state <= w_next;

  // next state and outputs; ready is masked during reset so every output reads 0
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  w_next = w_any ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: w_next = ARB_WAIT;
      ARB_WAIT:  w_next = (arb.sqrt_valid_i || w_expire) ? ARB_RESP : ARB_WAIT;
      default:   w_next = ARB_IDLE;
    endcase
    arb.req_ready_o = (rst && r_state == ARB_IDLE) ? w_onehot : '0;
    arb.sqrt_do_o = r_state == ARB_ISSUE;
    arb.sqrt_s_o = (r_state == ARB_ISSUE || r_state == ARB_WAIT) ? r_sig : '0;
    arb.rsp_valid_o = (r_state == ARB_RESP) ? NUM_REQ'(1) << r_gnt : '0;
    arb.rsp_res_o = (r_state == ARB_RESP) ? r_res : '0;
    arb.rsp_err_o = (r_state == ARB_RESP) && r_err;
    busy_o = r_state != ARB_IDLE;
  end

  // grant/operand capture, watchdog, result capture and pointer advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt <= '0;
      r_ptr <= '0;
      r_sig <= '0;
      r_res <= '0;
      r_err <= 1'b0;
      r_wd  <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_any) begin
        r_gnt <= w_idx;
        r_sig <= arb.req_sig_i[w_idx*SIG_W +: SIG_W];
      end
      if (r_state == ARB_ISSUE) r_wd <= '0;
      if (r_state == ARB_WAIT) begin
        if (arb.sqrt_valid_i) begin
          r_res <= arb.sqrt_res_i;
          r_err <= 1'b0;
        end else if (w_expire) begin
          r_res <= '0;
          r_err <= 1'b1;
        end else r_wd <= r_wd + 1'b1;
      end
      if (r_state == ARB_RESP) r_ptr <= (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sqrt_unit_arbiter.sv
// tb_sqrt_unit_arbiter: directed and random checks of the sqrt arbiter against a timing model
module tb_sqrt_unit_arbiter;
  import sqrt_unit_arbiter_pkg::*;
  localparam int N = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int cyc = 0;

  sqrt_unit_arbiter_if #(.NUM_REQ(N)) bus();
  sqrt_unit_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .arb(bus), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  bit auto_req = 0, cont = 0, wdraw = 0, stray = 0, inject = 0;
  int dp_lat = -1;
  logic [RES_W-1:0] dres_last = '0;

  logic [N-1:0] acc_seen = '0;
  int do_cyc = -1000, acc_cyc = 0, acc_idx = -1, rsp_cyc = 0, rsp_cnt = 0, ack3 = 0;
  logic [SIG_W-1:0] do_s = '0;
  logic [N-1:0] rsp_vec = '0;
  logic [RES_W-1:0] rsp_res = '0;
  logic rsp_err = 1'b0;
  int gq[$];

  bit m_act = 0;
  int m_ptr = 0, m_g = 0, m_t0 = 0, m_rc = 0;
  logic [SIG_W-1:0] m_sig = '0;
  logic [RES_W-1:0] m_res = '0;
  logic m_err = 1'b0;

  logic [N-1:0] e_rdy, e_rv;
  logic e_do, e_err, e_busy;
  logic [SIG_W-1:0] e_s;
  logic [RES_W-1:0] e_res;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    oh2i = -1;
    for (int i = 0; i < N; i++) if (v[i]) oh2i = i;
  endfunction

  // reference model: a request accepted at t0 launches at t0+1, waits from t0+2,
  // and answers one cycle after the first in-window valid or at t0+2+TO on timeout
  always @(negedge clk) begin
    bit found;
    int g;
    e_rdy = '0; e_rv = '0; e_do = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_s = '0; e_res = '0;
    if (rst) begin
      if (!m_act) begin
        found = 0;
        g = 0;
        for (int k = 0; k < N; k++)
          if (!found && bus.req_valid_i[(m_ptr + k) % N]) begin
            found = 1;
            g = (m_ptr + k) % N;
          end
        if (found) begin
          e_rdy[g] = 1'b1;
          m_act = 1; m_g = g; m_t0 = cyc; m_rc = cyc + 2 + TO;
          m_sig = bus.req_sig_i[g*SIG_W +: SIG_W]; m_res = '0; m_err = 1'b1;
        end
      end else begin
        e_busy = 1'b1;
        e_do = cyc == m_t0 + 1;
        e_s = (cyc > m_t0 && cyc < m_rc) ? m_sig : '0;
        if (cyc == m_rc) begin
          e_rv[m_g] = 1'b1; e_res = m_res; e_err = m_err;
          m_act = 0; m_ptr = (m_g + 1) % N;
        end else if (cyc >= m_t0 + 2 && bus.sqrt_valid_i) begin
          m_rc = cyc + 1; m_res = bus.sqrt_res_i; m_err = 1'b0;
        end
      end
    end else begin
      m_act = 0;
      m_ptr = 0;
    end
    check("ready", 32'(bus.req_ready_o), 32'(e_rdy));
    check("do", 32'(bus.sqrt_do_o), 32'(e_do));
    check("s", 32'(bus.sqrt_s_o), 32'(e_s));
    check("rsp_valid", 32'(bus.rsp_valid_o), 32'(e_rv));
    check("rsp_res", 32'(bus.rsp_res_o), 32'(e_res));
    check("rsp_err", 32'(bus.rsp_err_o), 32'(e_err));
    check("busy", 32'(busy), 32'(e_busy));
    acc_seen = rst ? bus.req_ready_o : '0;
    if (rst) begin
      if (|bus.req_ready_o) begin
        acc_cyc = cyc; acc_idx = oh2i(bus.req_ready_o); gq.push_back(acc_idx);
        if (bus.req_ready_o[3]) ack3++;
      end
      if (bus.sqrt_do_o) begin do_cyc = cyc; do_s = bus.sqrt_s_o; end
      if (|bus.rsp_valid_o) begin
        rsp_cnt++; rsp_cyc = cyc; rsp_vec = bus.rsp_valid_o;
        rsp_res = bus.rsp_res_o; rsp_err = bus.rsp_err_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_seen[i]) bus.req_valid_i[i] = 1'b0;
      else if (!bus.req_valid_i[i] && (cont || (auto_req && $urandom_range(3) == 0))) begin
        bus.req_valid_i[i] = 1'b1;
        bus.req_sig_i[i*SIG_W +: SIG_W] = SIG_W'($urandom);
      end else if (bus.req_valid_i[i] && wdraw && $urandom_range(31) == 0) bus.req_valid_i[i] = 1'b0;
    end
    bus.sqrt_valid_i = (dp_lat >= 0 && cyc == do_cyc + dp_lat) || inject || (stray && $urandom_range(19) == 0);
    inject = 0;
    if (bus.sqrt_valid_i) begin
      dres_last = RES_W'($urandom);
      bus.sqrt_res_i = dres_last;
    end else bus.sqrt_res_i = RES_W'($urandom);
  endtask

  task automatic set_req(input int i, input logic [SIG_W-1:0] s);
    bus.req_valid_i[i] = 1'b1;
    bus.req_sig_i[i*SIG_W +: SIG_W] = s;
  endtask

  task automatic apply_reset(input int hold);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid_i = '0;
    bus.sqrt_valid_i = 1'b0;
    repeat (hold) step();
    rst = 1'b1;
  endtask

  task automatic wait_rsp(input string nm, input int bud);
    int n0 = rsp_cnt;
    int k = 0;
    while (rsp_cnt == n0 && k < bud) begin step(); k++; end
    check(nm, 32'(rsp_cnt != n0), 32'd1);
  endtask

  task automatic wait_acc(input string nm, input int bud);
    int n0 = gq.size();
    int k = 0;
    while (gq.size() == n0 && k < bud) begin step(); k++; end
    check(nm, 32'(gq.size() != n0), 32'd1);
  endtask

  task automatic drain(input int bud);
    int k = 0;
    while ((busy || bus.req_valid_i != '0) && k < bud) begin step(); k++; end
    check("drain", 32'(busy || bus.req_valid_i != '0), 32'd0);
  endtask

  initial begin
    int n0, a3;
    bus.req_valid_i = '0; bus.req_sig_i = '0; bus.sqrt_valid_i = 1'b0; bus.sqrt_res_i = '0;
    repeat (2) step();
    bus.req_valid_i = '1;
    step();
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    bus.req_valid_i = '0;
    rst = 1'b1;
    step();
    // single request with a 5-cycle datapath
    dp_lat = 5;
    set_req(0, 8'h80);
    wait_rsp("t1_rsp", 40);
    check("t1_grant", 32'(acc_idx), 32'd0);
    check("t1_do_lat", 32'(do_cyc - acc_cyc), 32'd1);
    check("t1_do_s", 32'(do_s), 32'h80);
    check("t1_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd7);
    check("t1_rsp_vec", 32'(rsp_vec), 32'b0001);
    check("t1_err", 32'(rsp_err), 32'd0);
    check("t1_res", 32'(rsp_res), 32'(dres_last));
    gq.delete();
    set_req(0, 8'h11);
    set_req(1, 8'h22);
    wait_rsp("t1_p1", 40);
    wait_rsp("t1_p2", 40);
    check("t1_ptr_a", 32'(gq.size() > 1 ? gq[0] : -1), 32'd1);
    check("t1_ptr_b", 32'(gq.size() > 1 ? gq[1] : -1), 32'd0);
    // all four requesting from reset
    apply_reset(2);
    gq.delete();
    n0 = rsp_cnt;
    dp_lat = 3;
    cont = 1;
    for (int k = 0; k < 200 && gq.size() < 5; k++) step();
    check("t2_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("t2_order", 32'(gq.size() > i ? gq[i] : -1), 32'(i % N));
    check("t2_rsp_cnt", 32'(rsp_cnt - n0), 32'd4);
    cont = 0;
    drain(200);
    // datapath never answers in time; a late valid is dropped
    dp_lat = 70;
    set_req(2, 8'h05);
    wait_rsp("t3_rsp", 100);
    check("t3_lat", 32'(rsp_cyc - acc_cyc), 32'd66);
    check("t3_err", 32'(rsp_err), 32'd1);
    check("t3_res", 32'(rsp_res), 32'd0);
    check("t3_vec", 32'(rsp_vec), 32'b0100);
    n0 = rsp_cnt;
    repeat (12) step();
    check("t3_late", 32'(rsp_cnt - n0), 32'd0);
    // valid on the expiry cycle wins
    dp_lat = 64;
    set_req(1, 8'h00);
    wait_rsp("t4_rsp", 100);
    check("t4_lat", 32'(rsp_cyc - acc_cyc), 32'd66);
    check("t4_err", 32'(rsp_err), 32'd0);
    check("t4_res", 32'(rsp_res), 32'(dres_last));
    check("t4_vec", 32'(rsp_vec), 32'b0010);
    // reset during WAIT
    dp_lat = 20;
    set_req(3, 8'h3c);
    wait_acc("t5_acc", 20);
    repeat (5) step();
    apply_reset(3);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rsp", 32'(bus.rsp_valid_o), 32'd0);
    n0 = rsp_cnt;
    repeat (25) step();
    check("t5_stale", 32'(rsp_cnt - n0), 32'd0);
    gq.delete();
    bus.req_valid_i = 4'b1010;
    wait_rsp("t5_rsp1", 40);
    check("t5_ptr0", 32'(gq.size() > 0 ? gq[0] : -1), 32'd1);
    drain(100);
    dp_lat = 4;
    set_req(2, 8'h9a);
    wait_rsp("t5_rsp2", 40);
    check("t5_vec", 32'(rsp_vec), 32'b0100);
    check("t5_err", 32'(rsp_err), 32'd0);
    check("t5_res", 32'(rsp_res), 32'(dres_last));
    // withdrawn request is never acked; idle valid is ignored
    dp_lat = 10;
    a3 = ack3;
    set_req(1, 8'h44);
    wait_acc("t6_acc", 20);
    gq.delete();
    repeat (2) step();
    set_req(3, 8'h77);
    repeat (3) step();
    bus.req_valid_i[3] = 1'b0;
    set_req(2, 8'h55);
    wait_rsp("t6_rsp", 40);
    step();
    check("t6_next", 32'(gq.size() > 0 ? gq[0] : -1), 32'd2);
    drain(100);
    check("t6_no_ack3", 32'(ack3 - a3), 32'd0);
    n0 = rsp_cnt;
    inject = 1;
    repeat (6) step();
    check("t6_idle_valid", 32'(rsp_cnt - n0), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    // random traffic
    auto_req = 1; wdraw = 1; stray = 1;
    for (int b = 0; b < 30; b++) begin
      case ($urandom_range(3))
        0: dp_lat = $urandom_range(8);
        1: dp_lat = $urandom_range(68, 60);
        2: dp_lat = -1;
        default: dp_lat = $urandom_range(30, 9);
      endcase
      repeat (150) step();
      if (b % 7 == 3) apply_reset(2);
    end
    auto_req = 0; wdraw = 0; stray = 0; dp_lat = 5;
    drain(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(600_000);
    $display("FAIL time_limit: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end
endmodule
